regfile_write_master: RTL and testbench

//   Write-side initiator for the 32x64 register file (regwrite/adr_wr_reg/wr_data port).

---
 rtl/regfile_write_master_if.sv | 41 ++++
 rtl/regfile_write_master.sv | 179 +++++++++++++++++
 tb/tb_regfile_write_master.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_master_if.sv
// Register-file write interface: writeback request handshake plus the
// registered write port that feeds the 32x64 register file.
// The "master" modport is the write initiator (regfile_write_master); the
// "slave" modport is the environment (writeback stage and register file).
interface regfile_write_master_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5
);

    // Writeback request handshake
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;

    // Register-file write port
    logic              regwrite;
    logic [ADDR_W-1:0] adr_wr_reg;
    logic [DATA_W-1:0] wr_data;

    modport master (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready,
        output regwrite,
        output adr_wr_reg,
        output wr_data
    );

    modport slave (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready,
        input  regwrite,
        input  adr_wr_reg,
        input  wr_data
    );

endinterface

// File: rtl/regfile_write_master.sv
// Write-side initiator for the register file. Writeback requests are buffered
// in a small FIFO and issued one per clock on a registered write port. A
// bulk-initialise sequence drains the FIFO, then writes one captured value to
// registers 1..NUM_REGS-1 on consecutive cycles. Register 0 is never written.
module regfile_write_master #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    regfile_write_master_if.master            bus,
    input  logic                              init_start,
    input  logic [DATA_W-1:0]                 init_value,
    output logic                              init_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   pending_cnt
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CntW-1:0]   DepthCnt = CntW'(FIFO_DEPTH);
    localparam logic [PtrW-1:0]   LastPtr  = PtrW'(FIFO_DEPTH - 1);
    localparam logic [ADDR_W-1:0] FirstIdx = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StInit
    } state_t;

    // Control state
    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] init_val;

    // Registered write port
    logic              regwrite_q;
    logic [ADDR_W-1:0] adr_wr_reg_q;
    logic [DATA_W-1:0] wr_data_q;

    // Request FIFO
    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic [CntW-1:0]   count;
    logic [CntW-1:0]   count_next;

    logic              req_ready_int;
    logic              accept;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    // Ready depends only on state and occupancy; a full FIFO stays not-ready
    // even when the head is popped in the same cycle.
    assign req_ready_int = (state == StIdle) && (count < DepthCnt);
    assign accept        = bus.req_valid && req_ready_int;
    // Writes to x0 are accepted on the handshake but dropped here.
    assign push          = accept && (bus.req_addr != '0);
    // Buffered requests are issued in IDLE and DRAIN, never during INIT.
    assign pop           = (state != StInit) && (count != '0);

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Occupancy after this edge's push/pop
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CntW'(1);
            2'b01:   count_next = count - CntW'(1);
            default: count_next = count;
        endcase
    end

    // FIFO payload storage; contents are don't-care while unoccupied
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= bus.req_addr;
            data_mem[wr_ptr] <= bus.req_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_next;
        end
    end

    // Control FSM with registered register-file write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            idx          <= FirstIdx;
            init_val     <= '0;
            regwrite_q   <= 1'b0;
            adr_wr_reg_q <= '0;
            wr_data_q    <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (pop) begin
                        regwrite_q   <= 1'b1;
                        adr_wr_reg_q <= head_addr;
                        wr_data_q    <= head_data;
                    end else begin
                        regwrite_q   <= 1'b0;
                    end
                    if (init_start) begin
                        init_val <= init_value;
                        // A request taken alongside init_start must land first.
                        if ((count == '0) && !push) begin
                            state <= StInit;
                            idx   <= FirstIdx;
                        end else begin
                            state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (pop) begin
                        regwrite_q   <= 1'b1;
                        adr_wr_reg_q <= head_addr;
                        wr_data_q    <= head_data;
                    end else begin
                        regwrite_q   <= 1'b0;
                    end
                    // No pushes in DRAIN, so the FIFO only shrinks.
                    if (count_next == '0) begin
                        state <= StInit;
                        idx   <= FirstIdx;
                    end
                end
                StInit: begin
                    regwrite_q   <= 1'b1;
                    adr_wr_reg_q <= idx;
                    wr_data_q    <= init_val;
                    if (idx == LastIdx) begin
                        state <= StIdle;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                default: begin
                    state      <= StIdle;
                    regwrite_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_int;
    assign bus.regwrite   = regwrite_q;
    assign bus.adr_wr_reg = adr_wr_reg_q;
    assign bus.wr_data    = wr_data_q;
    assign init_busy      = (state == StDrain) || (state == StInit);
    assign pending_cnt    = count;

endmodule

// File: tb/tb_regfile_write_master.sv
// Self-checking bench for regfile_write_master. Expected register-file writes
// are kept as an ordered list of (addr, data) built from accepted requests and
// init sequences; every observed write must match the list head.
module tb_regfile_write_master;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 32;
    localparam int FD = 4;

    logic          clk;
    logic          rst;
    logic          init_start;
    logic [DW-1:0] init_value;
    logic          init_busy;
    logic [2:0]    pending_cnt;

    regfile_write_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_write_master #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .NUM_REGS  (NR),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .init_start (init_start),
        .init_value (init_value),
        .init_busy  (init_busy),
        .pending_cnt(pending_cnt)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    // Scoreboard: every write-port pulse must be the next expected write.
    always @(negedge clk) begin
        if (!rst && bus.regwrite === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got adr=%0d data=%h, required no write",
                         bus.adr_wr_reg, bus.wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.adr_wr_reg !== e.addr || bus.wr_data !== e.data) begin
                    errors++;
                    $display("FAIL write_order: got adr=%0d data=%h, required adr=%0d data=%h",
                             bus.adr_wr_reg, bus.wr_data, e.addr, e.data);
                end
            end
        end
    end

    function automatic logic [DW-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Expected writes of a bulk init: registers 1..NR-1 with one value
    task automatic plan_init(input logic [DW-1:0] v);
        for (int r = 1; r < NR; r++) begin
            wr_t e;
            e.addr = AW'(r);
            e.data = v;
            exp_q.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, output bit ok);
        int g = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        while (bus.req_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        ok = (g < 50);
        if (ok && a != '0) begin
            wr_t e;
            e.addr = a;
            e.data = d;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Waits (bounded) until every expected write has been observed.
    task automatic drain(output bit ok);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        ok = (exp_q.size() == 0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1)
            begin errors++; $display("FAIL reset_ready: got %b, required 1", bus.req_ready); end
        checks++;
        if (bus.regwrite !== 1'b0 || pending_cnt !== 3'd0 || init_busy !== 1'b0 ||
            bus.adr_wr_reg !== 5'd0 || bus.wr_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: got rw=%b cnt=%0d busy=%b adr=%0d data=%h, required all 0",
                     bus.regwrite, pending_cnt, init_busy, bus.adr_wr_reg, bus.wr_data);
        end
        // Reset with an entry buffered
        send(5'd7, rnd64(), ok);
        checks++;
        if (!ok || pending_cnt !== 3'd1)
            begin errors++; $display("FAIL reset_pre_cnt: got ok=%b cnt=%0d, required 1/1", ok, pending_cnt); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pending_cnt !== 3'd0)
            begin errors++; $display("FAIL reset_async_cnt: got %0d, required 0", pending_cnt); end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        // Reset while the write port is active
        send(5'd9, rnd64(), ok);
        @(posedge clk);
        #2;
        checks++;
        if (bus.regwrite !== 1'b1)
            begin errors++; $display("FAIL reset_pre_rw: got %b, required 1", bus.regwrite); end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.regwrite !== 1'b0 || init_busy !== 1'b0 || pending_cnt !== 3'd0)
            begin errors++; $display("FAIL reset_async_rw: got rw=%b busy=%b cnt=%0d, required 0/0/0",
                                     bus.regwrite, init_busy, pending_cnt); end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1)
            begin errors++; $display("FAIL reset_release_ready: got %b, required 1", bus.req_ready); end
    endtask

    task automatic test_single();
        bit ok;
        send(5'd2, 64'hAABBCCDDAABBCCDD, ok);
        checks++;
        if (!ok || bus.regwrite !== 1'b0)
            begin errors++; $display("FAIL single_n: got ok=%b rw=%b, required 1/0", ok, bus.regwrite); end
        @(negedge clk);
        checks++;
        if (bus.regwrite !== 1'b1 || bus.adr_wr_reg !== 5'd2 || bus.wr_data !== 64'hAABBCCDDAABBCCDD)
            begin errors++; $display("FAIL single_n1: got rw=%b adr=%0d data=%h, required 1/2/aabbccddaabbccdd",
                                     bus.regwrite, bus.adr_wr_reg, bus.wr_data); end
        @(negedge clk);
        checks++;
        if (bus.regwrite !== 1'b0)
            begin errors++; $display("FAIL single_n2: got rw=%b, required 0", bus.regwrite); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int mcnt = 0;
        int highs = 0;
        for (int i = 0; i < 6; i++) begin
            wr_t e;
            checks++;
            if (pending_cnt !== 3'(mcnt) || bus.req_ready !== (mcnt < FD))
                begin errors++; $display("FAIL burst_cnt_ready: got cnt=%0d rdy=%b, required %0d/%b",
                                         pending_cnt, bus.req_ready, mcnt, mcnt < FD); end
            if (bus.regwrite === 1'b1) highs++;
            bus.req_valid = 1'b1;
            bus.req_addr  = AW'(3 + i);
            bus.req_data  = rnd64();
            e.addr = bus.req_addr;
            e.data = bus.req_data;
            exp_q.push_back(e);
            @(negedge clk);
            mcnt = mcnt + 1 - ((mcnt > 0) ? 1 : 0);
        end
        bus.req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (bus.regwrite === 1'b1) highs++;
            @(negedge clk);
        end
        checks++;
        if (highs != 6)
            begin errors++; $display("FAIL burst_one_per_cycle: got %0d write cycles, required 6", highs); end
        drain(ok);
        checks++;
        if (!ok)
            begin errors++; $display("FAIL burst_drain: got %0d writes missing, required 0", exp_q.size()); end
    endtask

    task automatic test_x0_discard();
        bit ok;
        send(5'd0, 64'hFFFFFFFFFFFFFFFF, ok);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!ok || bus.regwrite !== 1'b0 || pending_cnt !== 3'd0)
                begin errors++; $display("FAIL x0_discard: got ok=%b rw=%b cnt=%0d, required 1/0/0",
                                         ok, bus.regwrite, pending_cnt); end
            @(negedge clk);
        end
    endtask

    task automatic test_init_pending();
        bit ok;
        int busy_cycles = 0;
        logic [DW-1:0] v = 64'hFFAAFFAAFFAAFFAA;
        wr_t e;
        send(5'd5, rnd64(), ok);
        // Request 6 is accepted in the same cycle as init_start.
        bus.req_valid = 1'b1;
        bus.req_addr  = 5'd6;
        bus.req_data  = rnd64();
        init_start    = 1'b1;
        init_value    = v;
        checks++;
        if (!ok || bus.req_ready !== 1'b1)
            begin errors++; $display("FAIL init_pend_accept: got ok=%b rdy=%b, required 1/1", ok, bus.req_ready); end
        e.addr = 5'd6;
        e.data = bus.req_data;
        exp_q.push_back(e);
        plan_init(v);
        @(negedge clk);
        init_start = 1'b0;
        init_value = ~v;
        while (init_busy === 1'b1 && busy_cycles < 100) begin
            checks++;
            if (bus.req_ready !== 1'b0)
                begin errors++; $display("FAIL init_pend_ready: got %b, required 0", bus.req_ready); end
            busy_cycles++;
            // Requests and a second init_start must both be ignored while busy.
            bus.req_valid = 1'b1;
            bus.req_addr  = 5'd9;
            bus.req_data  = rnd64();
            init_start    = (busy_cycles == 5);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        init_start    = 1'b0;
        checks++;
        if (busy_cycles != 32)
            begin errors++; $display("FAIL init_pend_busy_len: got %0d, required 32", busy_cycles); end
        drain(ok);
        checks++;
        if (!ok)
            begin errors++; $display("FAIL init_pend_drain: got %0d writes missing, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_init();
        bit ok;
        int g = 0;
        init_start = 1'b1;
        init_value = rnd64();
        plan_init(init_value);
        @(negedge clk);
        init_start = 1'b0;
        while (!(bus.regwrite === 1'b1 && bus.adr_wr_reg === 5'd10) && g < 60) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (g >= 60)
            begin errors++; $display("FAIL mid_init_reach10: got no write to 10, required one"); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.regwrite !== 1'b0 || init_busy !== 1'b0 || bus.adr_wr_reg !== 5'd0)
            begin errors++; $display("FAIL mid_init_reset: got rw=%b busy=%b adr=%0d, required 0/0/0",
                                     bus.regwrite, init_busy, bus.adr_wr_reg); end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1)
            begin errors++; $display("FAIL mid_init_idle: got rdy=%b, required 1", bus.req_ready); end
        init_start = 1'b1;
        init_value = rnd64();
        plan_init(init_value);
        @(negedge clk);
        init_start = 1'b0;
        drain(ok);
        checks++;
        if (!ok)
            begin errors++; $display("FAIL mid_init_restart: got %0d writes missing, required 0", exp_q.size()); end
    endtask

    task automatic test_random();
        bit ok;
        int mcnt = 0;
        for (int c = 0; c < 300; c++) begin
            bit v;
            bit acc;
            logic [AW-1:0] a;
            checks++;
            if (pending_cnt !== 3'(mcnt) || bus.req_ready !== (mcnt < FD))
                begin errors++; $display("FAIL rand_cnt_ready: got cnt=%0d rdy=%b, required %0d/%b",
                                         pending_cnt, bus.req_ready, mcnt, mcnt < FD); end
            v = ($urandom_range(0, 3) != 0);
            a = AW'($urandom_range(0, 31));
            bus.req_valid = v;
            bus.req_addr  = a;
            bus.req_data  = rnd64();
            acc = v && (mcnt < FD);
            if (acc && a != '0) begin
                wr_t e;
                e.addr = a;
                e.data = bus.req_data;
                exp_q.push_back(e);
            end
            if ($urandom_range(0, 39) == 0) begin
                int g = 0;
                init_start = 1'b1;
                init_value = rnd64();
                plan_init(init_value);
                @(negedge clk);
                init_start    = 1'b0;
                bus.req_valid = 1'b0;
                while (init_busy === 1'b1 && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                mcnt = 0;
            end else begin
                @(negedge clk);
                mcnt = mcnt + ((acc && a != '0) ? 1 : 0) - ((mcnt > 0) ? 1 : 0);
            end
        end
        bus.req_valid = 1'b0;
        drain(ok);
        checks++;
        if (!ok)
            begin errors++; $display("FAIL rand_drain: got %0d writes missing, required 0", exp_q.size()); end
    endtask

    initial begin
        rst           = 1'b1;
        init_start    = 1'b0;
        init_value    = '0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_x0_discard();
        test_init_pending();
        test_reset_mid_init();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
